// File: rtl/i2c_master_burst.sv
// I2C burst master: 7-bit addressed write or read bursts of 1..MAX_BYTES bytes.
// The SCL period is four quarters of CLK_DIV clocks. SCL is low in q0/q1 and
// released in q2/q3. SDA changes at q0 and is sampled on the last clock of q2.
// The line drivers are registered, so both pins follow the FSM one clock
// later. Both pins lag by the same amount, so their relative timing is kept.
module i2c_master_burst #(
    parameter int CLK_DIV   = 4,
    parameter int MAX_BYTES = 16,
    parameter int LEN_W     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       addr,
    input  logic             rw,
    input  logic [LEN_W-1:0] len,
    input  logic             enable,
    input  logic [7:0]       wr_data,
    output logic             wr_ready,
    output logic [7:0]       data_read_master,
    output logic             rd_valid,
    output logic             ready,
    output logic             done,
    output logic             nack_err,
    inout  wire              i2c_sda,
    inout  wire              i2c_scl
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WR_BYTE,
        S_WR_ACK, S_RD_BYTE, S_RD_ACK, S_STOP
    } state_t;

    state_t           r_state;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_q;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;
    logic             r_rw;
    logic [LEN_W-1:0] r_cnt;
    logic             r_ack;
    logic             r_wr_ready;
    logic             r_rd_valid;
    logic             r_done;
    logic             r_ready;
    logic             r_nack;
    logic [7:0]       r_data;
    logic             r_sda_low;
    logic             r_scl_low;

    logic             w_qtick;
    logic             w_sample;
    logic             w_bit_end;
    logic             w_more;
    logic             w_sda_in;
    logic [LEN_W-1:0] w_len;
    logic             w_sda_low;
    logic             w_scl_low;

    assign w_qtick   = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_sample  = w_qtick && (r_q == 2'd2);
    assign w_bit_end = w_qtick && (r_q == 2'd3);
    // r_cnt holds the bytes left including the one in flight.
    assign w_more    = (r_cnt > LEN_W'(1));
    assign w_sda_in  = i2c_sda;

    // Normalise the requested length: zero means one byte, and oversize requests are clamped.
    always_comb begin
        w_len = len;
        if (len == '0)
            w_len = LEN_W'(1);
        else if (len > LEN_W'(MAX_BYTES))
            w_len = LEN_W'(MAX_BYTES);
    end

    // Line levels wanted for the current state and quarter (1 = pull low).
    always_comb begin
        w_scl_low = 1'b0;
        w_sda_low = 1'b0;
        case (r_state)
            S_START: begin
                w_sda_low = 1'b1;
                w_scl_low = r_q[1];
            end
            S_ADDR, S_WR_BYTE: begin
                w_scl_low = ~r_q[1];
                w_sda_low = ~r_shift[7];
            end
            S_ADDR_ACK, S_WR_ACK, S_RD_BYTE: begin
                w_scl_low = ~r_q[1];
            end
            S_RD_ACK: begin
                w_scl_low = ~r_q[1];
                w_sda_low = w_more;
            end
            S_STOP: begin
                w_scl_low = (r_q == 2'd0);
                w_sda_low = ~r_q[1];
            end
            default: begin
                w_scl_low = 1'b0;
                w_sda_low = 1'b0;
            end
        endcase
    end

    // Main FSM: quarter timing, shifting, byte counting and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_div      <= '0;
            r_q        <= 2'd0;
            r_bit      <= 3'd0;
            r_shift    <= 8'h00;
            r_rw       <= 1'b0;
            r_cnt      <= '0;
            r_ack      <= 1'b1;
            r_wr_ready <= 1'b0;
            r_rd_valid <= 1'b0;
            r_done     <= 1'b0;
            r_ready    <= 1'b1;
            r_nack     <= 1'b0;
            r_data     <= 8'h00;
            r_sda_low  <= 1'b0;
            r_scl_low  <= 1'b0;
        end else begin
            r_wr_ready <= 1'b0;
            r_rd_valid <= 1'b0;
            r_done     <= 1'b0;
            r_sda_low  <= w_sda_low;
            r_scl_low  <= w_scl_low;
            if (r_state == S_IDLE) begin
                r_div <= '0;
                r_q   <= 2'd0;
                r_bit <= 3'd0;
                if (enable && r_ready) begin
                    r_shift <= {addr, rw};
                    r_rw    <= rw;
                    r_cnt   <= w_len;
                    r_nack  <= 1'b0;
                    r_ready <= 1'b0;
                    r_state <= S_START;
                end
            end else begin
                if (w_qtick) begin
                    r_div <= '0;
                    r_q   <= r_q + 2'd1;
                end else begin
                    r_div <= r_div + 1'b1;
                end
                if (w_sample) begin
                    r_ack <= w_sda_in;
                    if (r_state == S_RD_BYTE) begin
                        r_shift <= {r_shift[6:0], w_sda_in};
                        if (r_bit == 3'd7) begin
                            r_data     <= {r_shift[6:0], w_sda_in};
                            r_rd_valid <= 1'b1;
                        end
                    end
                end
                if (w_bit_end) begin
                    case (r_state)
                        S_START: begin
                            r_bit   <= 3'd0;
                            r_state <= S_ADDR;
                        end
                        S_ADDR, S_WR_BYTE: begin
                            if (r_bit == 3'd7) begin
                                r_bit   <= 3'd0;
                                r_state <= (r_state == S_ADDR) ? S_ADDR_ACK : S_WR_ACK;
                            end else begin
                                r_bit   <= r_bit + 3'd1;
                                r_shift <= {r_shift[6:0], 1'b0};
                            end
                        end
                        S_ADDR_ACK: begin
                            if (r_ack) begin
                                r_nack  <= 1'b1;
                                r_state <= S_STOP;
                            end else if (!r_rw) begin
                                r_wr_ready <= 1'b1;
                                r_shift    <= wr_data;
                                r_state    <= S_WR_BYTE;
                            end else begin
                                r_state <= S_RD_BYTE;
                            end
                        end
                        S_WR_ACK: begin
                            if (r_ack) begin
                                r_nack  <= 1'b1;
                                r_state <= S_STOP;
                            end else if (w_more) begin
                                r_cnt      <= r_cnt - LEN_W'(1);
                                r_wr_ready <= 1'b1;
                                r_shift    <= wr_data;
                                r_state    <= S_WR_BYTE;
                            end else begin
                                r_state <= S_STOP;
                            end
                        end
                        S_RD_BYTE: begin
                            if (r_bit == 3'd7) begin
                                r_bit   <= 3'd0;
                                r_state <= S_RD_ACK;
                            end else begin
                                r_bit <= r_bit + 3'd1;
                            end
                        end
                        S_RD_ACK: begin
                            if (w_more) begin
                                r_cnt   <= r_cnt - LEN_W'(1);
                                r_state <= S_RD_BYTE;
                            end else begin
                                r_state <= S_STOP;
                            end
                        end
                        S_STOP: begin
                            r_done  <= 1'b1;
                            r_ready <= 1'b1;
                            r_state <= S_IDLE;
                        end
                        default: r_state <= S_IDLE;
                    endcase
                end
            end
        end
    end

    assign i2c_sda          = r_sda_low ? 1'b0 : 1'bz;
    assign i2c_scl          = r_scl_low ? 1'b0 : 1'bz;
    assign wr_ready         = r_wr_ready;
    assign rd_valid         = r_rd_valid;
    assign done             = r_done;
    assign ready            = r_ready;
    assign nack_err         = r_nack;
    assign data_read_master = r_data;

endmodule
